// File: rtl/video_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pack_pkg
//  Description : Shared types and helpers for the 24-bit video input packer.
//                Holds the packer state encoding, group geometry constants
//                and the DDR line-length calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pack_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FRAME = 3'd1,
        LINE  = 3'd2,
        LEND  = 3'd3,
        FEND  = 3'd4
    } state_t;

    // Eight 24-bit pixels fill exactly three 64-bit words.
    localparam int PIX_PER_GROUP   = 8;
    localparam int WORDS_PER_GROUP = 3;

    // 64-bit words needed for one line: ceil(3*width/8).
    function automatic logic [23:0] calc_line_length(input logic [11:0] width);
        logic [13:0] w_bytes;
        w_bytes = {2'b00, width} + {1'b0, width, 1'b0} + 14'd7;
        return {13'd0, w_bytes[13:3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_generator.sv
`default_nettype none
// ============================================================================
//  Module      : edge_generator
//  Description : Registered rising/falling edge detector (NORMAL mode).
//                Each edge pulse is one cycle wide and appears the cycle
//                after the level change is first sampled.
//  Ports       : clk, rst_n (async, active-low), i_sig level input,
//                o_rise / o_fall one-cycle edge pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_generator (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
            r_fall <= ~i_sig & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/video24bit_in_packer.sv
`default_nettype none
// ============================================================================
//  Module      : video24bit_in_packer
//  Description : Packs a gapped 24-bit RGB pixel stream into 64-bit words
//                (8 pixels -> 3 words) for the DDR write FIFO and issues one
//                write request per frame with base address, line length in
//                words and line count.
//  Ports       : pclk / prst_n (async, active-low); invsync, inhsync, inde,
//                indata video input; video_width/height/baseaddr frame
//                geometry; fifo_full back-pressure; wr_req, baseaddr,
//                ddr_line_length, ddr_col_length frame request; wr_data,
//                wr_data_en FIFO write; req_end end-of-frame; overflow sticky.
//  Options     : VIDEO_PACKER_TEST_PATTERN_EN replaces indata with
//                {line_cnt[7:0], pix_cnt[15:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module video24bit_in_packer
    import video_pack_pkg::*;
#(
    parameter int ADDR_BITS = 25
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic                 invsync,
    input  logic                 inhsync,
    input  logic                 inde,
    input  logic [23:0]          indata,
    input  logic [23:0]          video_width,
    input  logic [11:0]          video_height,
    input  logic [ADDR_BITS-1:0] video_baseaddr,
    input  logic                 fifo_full,
    output logic                 wr_req,
    output logic [ADDR_BITS-1:0] baseaddr,
    output logic [23:0]          ddr_line_length,
    output logic [11:0]          ddr_col_length,
    output logic [63:0]          wr_data,
    output logic                 wr_data_en,
    output logic                 req_end,
    output logic                 overflow
);

    localparam int PHASE_W = $clog2(PIX_PER_GROUP);

    // Frame parameters
    logic [11:0]          r_width;
    logic [11:0]          r_height;
    logic [ADDR_BITS-1:0] r_baseaddr;
    logic [23:0]          r_line_len;

    // Control state
    state_t               r_state;
    logic [PHASE_W-1:0]   r_phase;
    logic [11:0]          r_pix_cnt;
    logic [11:0]          r_line_cnt;
    logic [63:0]          r_acc;
    logic                 r_tail_pend;
    logic                 r_wait_low;

    // Registered outputs
    logic                 r_wr_req;
    logic                 r_req_end;
    logic [63:0]          r_wr_data;
    logic                 r_wr_data_en;
    logic                 r_overflow;

    logic                 w_rise;
    logic                 w_fall;
    logic [23:0]          w_pixel;
    logic                 w_accept;
    logic                 w_last;
    logic [63:0]          w_acc_ins;
    logic [63:0]          w_word;
    logic [63:0]          w_leftover;
    logic                 w_word_done;
    logic                 w_has_left;
    logic                 w_emit;
    logic [63:0]          w_emit_word;
    logic                 w_unused;

    edge_generator u_vsync_edge (
        .clk    (pclk),
        .rst_n  (prst_n),
        .i_sig  (invsync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

`ifdef VIDEO_PACKER_TEST_PATTERN_EN
    assign w_pixel  = {r_line_cnt[7:0], 4'd0, r_pix_cnt};
    assign w_unused = ^{inhsync, indata, video_width[23:12]};
`else
    assign w_pixel  = indata;
    assign w_unused = ^{inhsync, video_width[23:12]};
`endif

    // Geometry follows the inputs during vertical blanking, frozen otherwise.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_width    <= 12'd0;
            r_height   <= 12'd0;
            r_baseaddr <= '0;
            r_line_len <= 24'd0;
        end else if (invsync) begin
            r_width    <= video_width[11:0];
            r_height   <= video_height;
            r_baseaddr <= video_baseaddr;
            r_line_len <= calc_line_length(video_width[11:0]);
        end
    end

    // Once a line is complete, inde must drop before the next line counts.
    assign w_accept = (r_state == LINE) && inde && !r_wait_low;
    assign w_last   = ((r_pix_cnt + 12'd1) == r_width);

    // Byte placement of the current pixel into the word under construction.
    always_comb begin
        w_acc_ins   = r_acc;
        w_word      = 64'd0;
        w_leftover  = 64'd0;
        w_word_done = 1'b0;
        w_has_left  = 1'b0;
        case (r_phase)
            3'd0: w_acc_ins[63:40] = w_pixel;
            3'd1: w_acc_ins[39:16] = w_pixel;
            3'd2: begin
                w_word      = {r_acc[63:16], w_pixel[23:8]};
                w_leftover  = {w_pixel[7:0], 56'd0};
                w_word_done = 1'b1;
                w_has_left  = 1'b1;
            end
            3'd3: w_acc_ins[55:32] = w_pixel;
            3'd4: w_acc_ins[31:8]  = w_pixel;
            3'd5: begin
                w_word      = {r_acc[63:8], w_pixel[23:16]};
                w_leftover  = {w_pixel[15:0], 48'd0};
                w_word_done = 1'b1;
                w_has_left  = 1'b1;
            end
            3'd6: w_acc_ins[47:24] = w_pixel;
            default: begin
                w_word      = {r_acc[63:24], w_pixel};
                w_word_done = 1'b1;
            end
        endcase
    end

    // A line ending on p2/p5 leaves a few bytes behind; they go out as a
    // zero-padded tail word from LEND, one idle cycle after the previous
    // word so writes never run back to back.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_word = r_acc;
        if (!w_rise) begin
            if (w_accept && (w_word_done || w_last)) begin
                w_emit      = 1'b1;
                w_emit_word = w_word_done ? w_word : w_acc_ins;
            end else if ((r_state == LEND) && r_tail_pend && !r_wr_data_en) begin
                w_emit      = 1'b1;
                w_emit_word = r_acc;
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_pix_cnt    <= 12'd0;
            r_line_cnt   <= 12'd0;
            r_acc        <= 64'd0;
            r_tail_pend  <= 1'b0;
            r_wait_low   <= 1'b0;
            r_wr_req     <= 1'b0;
            r_req_end    <= 1'b0;
            r_wr_data    <= 64'd0;
            r_wr_data_en <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_req     <= 1'b0;
            r_req_end    <= 1'b0;
            r_wr_data_en <= 1'b0;
            if (!inde) begin
                r_wait_low <= 1'b0;
            end
            if (w_emit) begin
                if (fifo_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_data_en <= 1'b1;
                    r_wr_data    <= w_emit_word;
                end
            end

            if (w_rise) begin
                // New vertical blank: abandon whatever was in flight.
                r_state     <= IDLE;
                r_phase     <= '0;
                r_pix_cnt   <= 12'd0;
                r_line_cnt  <= 12'd0;
                r_acc       <= 64'd0;
                r_tail_pend <= 1'b0;
                r_wait_low  <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_phase     <= '0;
                        r_pix_cnt   <= 12'd0;
                        r_line_cnt  <= 12'd0;
                        r_acc       <= 64'd0;
                        r_tail_pend <= 1'b0;
                        if (w_fall) begin
                            r_state <= FRAME;
                        end
                    end
                    FRAME: begin
                        r_wr_req <= 1'b1;
                        if ((r_width == 12'd0) || (r_height == 12'd0)) begin
                            r_state   <= FEND;
                            r_req_end <= 1'b1;
                        end else begin
                            r_state <= LINE;
                        end
                    end
                    LINE: begin
                        if (w_accept) begin
                            r_phase   <= r_phase + 3'd1;
                            r_pix_cnt <= r_pix_cnt + 12'd1;
                            r_acc     <= w_word_done ? w_leftover : w_acc_ins;
                            if (w_last) begin
                                r_phase     <= '0;
                                r_pix_cnt   <= 12'd0;
                                r_line_cnt  <= r_line_cnt + 12'd1;
                                r_wait_low  <= 1'b1;
                                r_tail_pend <= w_has_left;
                                if (!w_has_left) begin
                                    r_acc <= 64'd0;
                                end
                                r_state <= LEND;
                            end
                        end
                    end
                    LEND: begin
                        if (r_tail_pend) begin
                            if (!r_wr_data_en) begin
                                r_tail_pend <= 1'b0;
                                r_acc       <= 64'd0;
                            end
                        end else if (r_line_cnt >= r_height) begin
                            r_state   <= FEND;
                            r_req_end <= 1'b1;
                        end else begin
                            r_state <= LINE;
                        end
                    end
                    FEND: begin
                        r_state <= FEND;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_req          = r_wr_req;
    assign baseaddr        = r_baseaddr;
    assign ddr_line_length = r_line_len;
    assign ddr_col_length  = r_height;
    assign wr_data         = r_wr_data;
    assign wr_data_en      = r_wr_data_en;
    assign req_end         = r_req_end;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire
